// File: rtl/ser_pkg.sv
// Shared types and helpers for the symbol/bit error-rate meter.
package ser_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILL    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FILL    = ST_FILL,
    MEASURE = ST_MEASURE
  } state_t;

  // Widest symbol label the helper functions handle.
  localparam int unsigned MAX_SYM_W = 16;

  function automatic int unsigned bit_cnt_width(input int unsigned window_w,
                                                input int unsigned bits_per_sym);
    return window_w + $clog2(bits_per_sym + 1);
  endfunction

  function automatic logic [MAX_SYM_W-1:0] bin2gray(input logic [MAX_SYM_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_SYM_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_SYM_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sym_delay_line.sv
// Symbol-strobed reference delay line with saturating fill counter.
module sym_delay_line #(
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned DELAY        = 0
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sym_clk_ena,
  input  logic [BITS_PER_SYM-1:0] symb_in,
  output logic [BITS_PER_SYM-1:0] symb_out,
  output logic                    full
);

  if (DELAY == 0) begin : g_bypass
    logic ctl_unused;
    assign ctl_unused = &{1'b0, sys_clk, reset, sym_clk_ena};
    assign symb_out   = symb_in;
    assign full       = 1'b1;
  end else begin : g_line
    localparam int unsigned FILL_W = $clog2(DELAY + 1);
    localparam int unsigned LINE_W = DELAY * BITS_PER_SYM;

    // Newest symbol sits in the low bits; the oldest leaves from the top.
    logic [LINE_W-1:0] line;
    logic [FILL_W-1:0] fill_cnt;

    always_ff @(posedge sys_clk) begin
      if (reset) begin
        line     <= '0;
        fill_cnt <= '0;
      end else if (sym_clk_ena) begin
        line <= (line << BITS_PER_SYM) | LINE_W'(symb_in);
        if (fill_cnt != FILL_W'(DELAY)) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end

    assign symb_out = line[LINE_W-1 -: BITS_PER_SYM];
    assign full     = (fill_cnt == FILL_W'(DELAY));
  end

endmodule

// File: rtl/ser_meter.sv
// Symbol/bit error-rate meter: aligns reference to received symbols and
// counts symbols, symbol errors and bit errors over a programmable window.
module ser_meter
  import ser_pkg::*;
#(
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned DELAY        = 0,
  parameter int unsigned WINDOW_W     = 22,
  parameter int unsigned GRAY_MAP     = 1
) (
  input  logic                                                sys_clk,
  input  logic                                                reset,
  input  logic                                                sym_clk_ena,
  input  logic                                                start,
  input  logic [WINDOW_W-1:0]                                 window_len,
  input  logic [BITS_PER_SYM-1:0]                             symb_ref,
  input  logic [BITS_PER_SYM-1:0]                             symb_rx,
  output logic                                                busy,
  output logic                                                done,
  output logic [WINDOW_W-1:0]                                 sym_count,
  output logic [WINDOW_W-1:0]                                 sym_err_count,
  output logic [bit_cnt_width(WINDOW_W, BITS_PER_SYM)-1:0]    bit_err_count,
  output logic                                                sym_correct,
  output logic                                                sym_error
);

  localparam int unsigned BE_W = bit_cnt_width(WINDOW_W, BITS_PER_SYM);
  localparam int unsigned PC_W = $clog2(BITS_PER_SYM + 1);

  state_t                  state;
  logic [BITS_PER_SYM-1:0] ref_d;
  logic                    line_full;
  logic                    sym_valid;
  logic                    sym_mismatch;
  logic [PC_W-1:0]         sym_bit_errs;
  logic [MAX_SYM_W-1:0]    lab_ref;
  logic [MAX_SYM_W-1:0]    lab_rx;
  logic [WINDOW_W:0]       serr_sum;
  logic [BE_W:0]           berr_sum;
  logic [WINDOW_W-1:0]     serr_next;
  logic [BE_W-1:0]         berr_next;
  logic [WINDOW_W-1:0]     sym_count_inc;
  logic [WINDOW_W-1:0]     win_len;

  sym_delay_line #(
    .BITS_PER_SYM (BITS_PER_SYM),
    .DELAY        (DELAY)
  ) u_delay (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sym_clk_ena (sym_clk_ena),
    .symb_in     (symb_ref),
    .symb_out    (ref_d),
    .full        (line_full)
  );

  always_comb begin
    lab_ref = MAX_SYM_W'(ref_d);
    lab_rx  = MAX_SYM_W'(symb_rx);
    if (GRAY_MAP != 0) begin
      lab_ref = bin2gray(lab_ref);
      lab_rx  = bin2gray(lab_rx);
    end
    sym_valid     = sym_clk_ena & line_full;
    sym_mismatch  = (ref_d != symb_rx);
    sym_bit_errs  = PC_W'(popcount(lab_ref ^ lab_rx));
    // One spare bit catches the carry so the error counters can saturate.
    serr_sum      = {1'b0, sym_err_count} + (WINDOW_W+1)'(sym_mismatch);
    berr_sum      = {1'b0, bit_err_count} + (BE_W+1)'(sym_bit_errs);
    serr_next     = serr_sum[WINDOW_W] ? '1 : serr_sum[WINDOW_W-1:0];
    berr_next     = berr_sum[BE_W] ? '1 : berr_sum[BE_W-1:0];
    sym_count_inc = sym_count + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sym_correct   <= 1'b0;
      sym_error     <= 1'b0;
      sym_count     <= '0;
      sym_err_count <= '0;
      bit_err_count <= '0;
      win_len       <= '0;
    end else begin
      sym_correct <= sym_valid & ~sym_mismatch;
      sym_error   <= sym_valid & sym_mismatch;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sym_count     <= '0;
            sym_err_count <= '0;
            bit_err_count <= '0;
            win_len       <= window_len;
            if (window_len == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= line_full ? MEASURE : FILL;
            end
          end
        end
        FILL, MEASURE: begin
          // sym_valid already implies an aligned pair, so a strobe seen in FILL counts too.
          if (sym_valid) begin
            sym_count     <= sym_count_inc;
            sym_err_count <= serr_next;
            bit_err_count <= berr_next;
            if (sym_count_inc == win_len) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= MEASURE;
            end
          end else if (line_full) begin
            state <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_meter.sv
// Randomised bench for ser_meter: three configurations share one stimulus
// stream and are each checked every cycle against a strobe-level model.
module tb_ser_meter;

  localparam int unsigned NDUT = 3;
  localparam int unsigned WW   = 22;
  localparam int unsigned BEW  = WW + 2;
  localparam int unsigned DLY [NDUT] = '{3, 3, 0};
  localparam int unsigned GRY [NDUT] = '{1, 0, 1};

  logic          clk = 1'b0;
  logic          reset;
  logic          sym_clk_ena;
  logic          start;
  logic [WW-1:0] window_len;
  logic [1:0]    symb_ref;
  logic [1:0]    symb_rx;

  logic [NDUT-1:0] busy_w, done_w, cor_w, err_w;
  logic [WW-1:0]   cnt_w  [NDUT];
  logic [WW-1:0]   serr_w [NDUT];
  logic [BEW-1:0]  berr_w [NDUT];

  always #5 clk = ~clk;

  ser_meter #(.BITS_PER_SYM(2), .DELAY(3), .WINDOW_W(WW), .GRAY_MAP(1)) u_dut0 (
    .sys_clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start),
    .window_len(window_len), .symb_ref(symb_ref), .symb_rx(symb_rx),
    .busy(busy_w[0]), .done(done_w[0]), .sym_count(cnt_w[0]), .sym_err_count(serr_w[0]),
    .bit_err_count(berr_w[0]), .sym_correct(cor_w[0]), .sym_error(err_w[0]));

  ser_meter #(.BITS_PER_SYM(2), .DELAY(3), .WINDOW_W(WW), .GRAY_MAP(0)) u_dut1 (
    .sys_clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start),
    .window_len(window_len), .symb_ref(symb_ref), .symb_rx(symb_rx),
    .busy(busy_w[1]), .done(done_w[1]), .sym_count(cnt_w[1]), .sym_err_count(serr_w[1]),
    .bit_err_count(berr_w[1]), .sym_correct(cor_w[1]), .sym_error(err_w[1]));

  ser_meter #(.BITS_PER_SYM(2), .DELAY(0), .WINDOW_W(WW), .GRAY_MAP(1)) u_dut2 (
    .sys_clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start),
    .window_len(window_len), .symb_ref(symb_ref), .symb_rx(symb_rx),
    .busy(busy_w[2]), .done(done_w[2]), .sym_count(cnt_w[2]), .sym_err_count(serr_w[2]),
    .bit_err_count(berr_w[2]), .sym_correct(cor_w[2]), .sym_error(err_w[2]));

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model state
  bit          m_active [NDUT];
  bit          m_busy   [NDUT];
  bit          m_done   [NDUT];
  bit          m_cor    [NDUT];
  bit          m_err    [NDUT];
  int unsigned m_cnt    [NDUT];
  int unsigned m_serr   [NDUT];
  int unsigned m_berr   [NDUT];
  int unsigned m_win    [NDUT];
  int unsigned done_seen[NDUT];
  logic [1:0]  hist[$];
  int unsigned n_strobe;
  logic [1:0]  tx_dly [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned label_errs(input logic [1:0] a, input logic [1:0] b,
                                             input int unsigned gray);
    logic [1:0] x, y;
    x = a;
    y = b;
    if (gray != 0) begin
      x = a ^ (a >> 1);
      y = b ^ (b >> 1);
    end
    return $countones(x ^ y);
  endfunction

  function automatic bit any_active();
    for (int k = 0; k < NDUT; k++) if (m_active[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_done_seen();
    for (int k = 0; k < NDUT; k++) done_seen[k] = 0;
  endtask

  // Expected outputs after the coming clock edge, from the strobe history.
  task automatic model(input bit rst, input bit ena, input bit st, input logic [WW-1:0] wl,
                       input logic [1:0] rf, input logic [1:0] rx);
    for (int k = 0; k < NDUT; k++) begin
      bit valid;
      logic [1:0] a;
      if (rst) begin
        m_active[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cor[k] = 0; m_err[k] = 0;
        m_cnt[k] = 0; m_serr[k] = 0; m_berr[k] = 0;
      end else begin
        valid = ena && (n_strobe >= DLY[k]);
        a = rf;
        if (valid && DLY[k] != 0) a = hist[n_strobe - DLY[k]];
        m_cor[k]  = valid && (a == rx);
        m_err[k]  = valid && (a != rx);
        m_done[k] = 0;
        if (m_active[k]) begin
          if (valid) begin
            m_cnt[k]++;
            if (a != rx) m_serr[k]++;
            m_berr[k] += label_errs(a, rx, GRY[k]);
            if (m_cnt[k] == m_win[k]) begin
              m_active[k] = 0;
              m_done[k]   = 1;
            end
          end
        end else if (st) begin
          m_cnt[k] = 0; m_serr[k] = 0; m_berr[k] = 0;
          m_win[k] = wl;
          if (wl == 0) m_done[k] = 1;
          else m_active[k] = 1;
        end
        m_busy[k] = m_active[k];
      end
    end
    if (rst) begin
      hist.delete();
      n_strobe = 0;
    end else if (ena) begin
      hist.push_back(rf);
      n_strobe++;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
      check_eq($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
      check_eq($sformatf("sym_correct[%0d]", k), 32'(cor_w[k]), 32'(m_cor[k]));
      check_eq($sformatf("sym_error[%0d]", k), 32'(err_w[k]), 32'(m_err[k]));
      check_eq($sformatf("sym_count[%0d]", k), 32'(cnt_w[k]), m_cnt[k]);
      check_eq($sformatf("sym_err_count[%0d]", k), 32'(serr_w[k]), m_serr[k]);
      check_eq($sformatf("bit_err_count[%0d]", k), 32'(berr_w[k]), m_berr[k]);
      done_seen[k] += 32'(done_w[k]);
    end
  endtask

  task automatic step(input bit rst, input bit ena, input bit st, input logic [WW-1:0] wl,
                      input logic [1:0] rf, input logic [1:0] rx);
    reset       = rst;
    sym_clk_ena = ena;
    start       = st;
    window_len  = wl;
    symb_ref    = rf;
    symb_rx     = rx;
    model(rst, ena, st, wl, rf, rx);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input bit st, input logic [WW-1:0] wl);
    step(1'b0, 1'b0, st, wl, 2'($urandom), 2'($urandom));
  endtask

  // rx follows the reference three strobes late, optionally corrupted.
  task automatic strobe_step(input bit st, input logic [WW-1:0] wl, input bit force_flip,
                             input int unsigned err_pct);
    logic [1:0] rf, rx;
    rf = 2'($urandom);
    rx = tx_dly[2];
    if (force_flip) rx = rx ^ 2'b11;
    else if ($urandom_range(99) < err_pct) rx = 2'($urandom);
    tx_dly[2] = tx_dly[1];
    tx_dly[1] = tx_dly[0];
    tx_dly[0] = rf;
    step(1'b0, 1'b1, st, wl, rf, rx);
  endtask

  task automatic run_meas(input logic [WW-1:0] wl, input bit flip4, input bit coinc,
                          input int unsigned err_pct, input bit extra_starts,
                          input int unsigned max_gap);
    int unsigned cyc, sidx;
    if (coinc) strobe_step(1'b1, wl, 1'b0, err_pct);
    else idle_step(1'b1, wl);
    cyc  = 0;
    sidx = 0;
    while (any_active() && cyc < 600) begin
      repeat ($urandom_range(max_gap)) begin
        idle_step(extra_starts && ($urandom_range(3) == 0), WW'($urandom_range(1, 40)));
        cyc++;
      end
      sidx++;
      strobe_step(extra_starts && ($urandom_range(3) == 0), WW'($urandom_range(1, 40)),
                  flip4 && (sidx inside {2, 5, 9, 13}), err_pct);
      cyc++;
    end
    check_eq("run_end_busy", 32'(busy_w), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_strobe = 0;
    tx_dly   = '{default: 2'b00};
    for (int k = 0; k < NDUT; k++) begin
      m_active[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cor[k] = 0; m_err[k] = 0;
      m_cnt[k] = 0; m_serr[k] = 0; m_berr[k] = 0; m_win[k] = 0; done_seen[k] = 0;
    end
    reset = 1'b1; sym_clk_ena = 1'b0; start = 1'b0; window_len = '0;
    symb_ref = '0; symb_rx = '0;
    @(negedge clk);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
    check_eq("reset_busy", 32'(busy_w), 32'd0);
    check_eq("reset_cnt0", 32'(cnt_w[0]), 32'd0);

    // Clean window of 16 straight after reset: DELAY=3 units fill first.
    clear_done_seen();
    run_meas(16, 1'b0, 1'b0, 0, 1'b0, 2);
    check_eq("clean_cnt", 32'(cnt_w[0]), 32'd16);
    check_eq("clean_serr", 32'(serr_w[0]), 32'd0);
    check_eq("clean_berr", 32'(berr_w[0]), 32'd0);
    check_eq("clean_done_pulses", done_seen[0], 32'd1);
    repeat (3) idle_step(1'b0, '0);

    // Four 0<->3 style label flips: Gray -> 1 bit each, binary -> 2 bits each.
    run_meas(16, 1'b1, 1'b0, 0, 1'b0, 1);
    check_eq("flip_cnt", 32'(cnt_w[0]), 32'd16);
    check_eq("flip_serr", 32'(serr_w[0]), 32'd4);
    check_eq("flip_berr_gray", 32'(berr_w[0]), 32'd4);
    check_eq("flip_berr_bin", 32'(berr_w[1]), 32'd8);
    check_eq("flip_serr_bin", 32'(serr_w[1]), 32'd4);

    // Start right after reset: the DELAY=0 unit measures at once.
    step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
    clear_done_seen();
    run_meas(5, 1'b0, 1'b0, 0, 1'b0, 1);
    check_eq("d0_cnt", 32'(cnt_w[2]), 32'd5);
    check_eq("d0_done_pulses", done_seen[2], 32'd1);

    // Zero-length window.
    idle_step(1'b1, '0);
    check_eq("w0_done", 32'(done_w), 32'd7);
    check_eq("w0_busy", 32'(busy_w), 32'd0);
    check_eq("w0_cnt", 32'(cnt_w[0]), 32'd0);
    idle_step(1'b0, '0);
    check_eq("w0_done_clear", 32'(done_w), 32'd0);

    // Reset in the middle of a measurement, then a fresh one.
    idle_step(1'b1, 16);
    repeat (7) strobe_step(1'b0, 16, 1'b0, 30);
    step(1'b1, 1'b0, 1'b0, 16, 2'b00, 2'b00);
    check_eq("midrst_busy", 32'(busy_w), 32'd0);
    check_eq("midrst_done", 32'(done_w), 32'd0);
    check_eq("midrst_cor", 32'(cor_w), 32'd0);
    check_eq("midrst_err", 32'(err_w), 32'd0);
    check_eq("midrst_cnt", 32'(cnt_w[0]), 32'd0);
    check_eq("midrst_serr", 32'(serr_w[0]), 32'd0);
    check_eq("midrst_berr", 32'(berr_w[0]), 32'd0);
    run_meas(16, 1'b0, 1'b0, 10, 1'b0, 2);
    check_eq("restart_cnt", 32'(cnt_w[0]), 32'd16);

    // Start coincident with a strobe, plus stray starts while busy.
    run_meas(12, 1'b0, 1'b1, 20, 1'b1, 2);
    check_eq("coinc_cnt", 32'(cnt_w[0]), 32'd12);

    // Random windows, error rates, gaps and start placement.
    repeat (12) begin
      run_meas(WW'($urandom_range(0, 30)), 1'b0, 1'($urandom_range(1)),
               $urandom_range(40), 1'($urandom_range(1)), $urandom_range(3));
      repeat ($urandom_range(2)) idle_step(1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
